// File: rtl/meter_ctrl.sv
`timescale 1ns/1ps
// meter_ctrl: 4-digit BCD countdown meter. Add pulses top up the remaining
// time, two load levels preset it, a 1 s prescaler counts it down, and a
// small display FSM drives the digit enable (solid, 1 s blink, 0.5 s flash).
module meter_ctrl #(
    parameter int unsigned TICK_DIV = 100000000
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        add10,
    input  logic        add180,
    input  logic        add200,
    input  logic        add550,
    input  logic        ld15,
    input  logic        ld185,
    output logic [15:0] bcd,
    output logic        disp_en,
    output logic        expired
);

    localparam int unsigned   CW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(TICK_DIV / 2 - 1);

    typedef enum logic [1:0] {SOLID, BLINK, FLASH} disp_state_e;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   bcd_q, bcd_d;
    logic          pend_q, pend_d;
    logic          disp_q, disp_d;
    logic          expired_q, expired_d;
    disp_state_e   state_q, state_d;

    logic          load;
    logic          tick;
    logic          half_tick;
    logic          add_hit;
    logic [15:0]   add_inc;
    logic [16:0]   add_sum;

    // Digit-serial BCD add; bit 16 is the carry out of the thousands digit.
    function automatic logic [16:0] bcd_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] res;
        logic [4:0]  dsum;
        logic        cy;
        res = '0;
        cy  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dsum = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0000, cy};
            if (dsum > 5'd9) begin
                dsum = dsum - 5'd10;
                cy   = 1'b1;
            end else begin
                cy   = 1'b0;
            end
            res[4*i +: 4] = dsum[3:0];
        end
        res[16] = cy;
        return res;
    endfunction

    // BCD decrement by one; a 0 digit borrows and wraps to 9. Only used on nonzero values.
    function automatic logic [15:0] bcd_dec(input logic [15:0] a);
        logic [15:0] res;
        logic        bw;
        res = a;
        bw  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (bw) begin
                if (a[4*i +: 4] == 4'd0) begin
                    res[4*i +: 4] = 4'd9;
                end else begin
                    res[4*i +: 4] = a[4*i +: 4] - 4'd1;
                    bw            = 1'b0;
                end
            end
        end
        return res;
    endfunction

    // A load level freezes the prescaler, so no tick or half tick can fire under it.
    assign load      = ld185 | ld15;
    assign tick      = ~load & (cnt_q == LAST);
    assign half_tick = ~load & ((cnt_q == HALF) | (cnt_q == LAST));
    assign add_sum   = bcd_add(bcd_q, add_inc);

    // Pick the single highest-priority add pulse; lower ones are dropped.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        add_hit = 1'b1;
        add_inc = 16'h0000;
        if (add10)       add_inc = 16'h0010;
        else if (add180) add_inc = 16'h0180;
        else if (add200) add_inc = 16'h0200;
        else if (add550) add_inc = 16'h0550;
        else             add_hit = 1'b0;
    end

    // Next remaining time, prescaler and pending-tick flag in priority order.
    always_comb begin
        cnt_d  = (load || tick) ? '0 : cnt_q + CW'(1);
        bcd_d  = bcd_q;
        pend_d = pend_q;
        if (ld185) begin
            bcd_d  = 16'h0185;
            pend_d = 1'b0;
        end else if (ld15) begin
            bcd_d  = 16'h0015;
            pend_d = 1'b0;
        end else if (add_hit) begin
            bcd_d = add_sum[16] ? 16'h9999 : add_sum[15:0];
            if (tick) pend_d = 1'b1;
        end else if (tick || pend_q) begin
            pend_d = 1'b0;
            if (bcd_q != 16'h0000) bcd_d = bcd_dec(bcd_q);
        end
        expired_d = (bcd_d == 16'h0000);
    end

    // Display mode follows the next time value; entering a mode always starts lit.
    always_comb begin
        state_d = SOLID;
        disp_d  = 1'b1;
        if (load)                     state_d = BLINK;
        else if (bcd_d == 16'h0000)   state_d = FLASH;
        else if (bcd_d < 16'h0200)    state_d = BLINK;
        if (!load && state_d == state_q) begin
            case (state_d)
                BLINK:   disp_d = tick      ? ~disp_q : disp_q;
                FLASH:   disp_d = half_tick ? ~disp_q : disp_q;
                default: disp_d = 1'b1;
            endcase
        end
    end

    // State registers; clearing drops any add or tick in flight.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_q     <= '0;
            bcd_q     <= 16'h0000;
            pend_q    <= 1'b0;
            disp_q    <= 1'b1;
            expired_q <= 1'b1;
            state_q   <= FLASH;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from the same pre-edge values.
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            pend_q    <= pend_d;
            disp_q    <= disp_d;
            expired_q <= expired_d;
            state_q   <= state_d;
        end
    end

    assign bcd     = bcd_q;
    assign disp_en = disp_q;
    assign expired = expired_q;

endmodule

// File: doc/meter_ctrl.md
METER_CTRL -- requirements
Module: meter_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 100000000, clk cycles per 1 s tick; SHALL be even and >= 4.
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 clr_n  input  1  reset, asynchronous, active-low.
REQ-004 add10  input  1  one-cycle pulse (pre-debounced single pulse): add 10 s.
REQ-005 add180  input  1  one-cycle pulse: add 180 s.
REQ-006 add200  input  1  one-cycle pulse: add 200 s.
REQ-007 add550  input  1  one-cycle pulse: add 550 s.
REQ-008 ld15  input  1  level: force time to 15 while high.
REQ-009 ld185  input  1  level: force time to 185 while high.
REQ-010 bcd  output  16  remaining time, 4 BCD digits, [15:12] thousands .. [3:0] ones, registered.
REQ-011 disp_en  output  1  display enable for the 4-digit driver (1 = lit), registered.
REQ-012 expired  output  1  high when bcd == 0000, registered.

Function
REQ-013 SHALL contain a prescaler counting 0..TICK_DIV-1; terminal count produces a one-cycle internal tick.
REQ-014 SHALL produce an internal half tick at count TICK_DIV/2-1 and at TICK_DIV-1.
REQ-015 Per-cycle priority SHALL be: ld185 > ld15 > add10 > add180 > add200 > add550 > tick decrement.
REQ-016 While ld185 high: bcd <= 0185; prescaler held at 0; all pulses and ticks discarded.
REQ-017 While ld15 high (ld185 low): bcd <= 0015; prescaler held at 0; pulses and ticks discarded.
REQ-018 Add pulse accepted: bcd <= BCD sum of bcd and increment, visible the next cycle (latency 1).
REQ-019 Simultaneous add pulses: only the highest-priority one applied; the others are dropped, not queued.
REQ-020 BCD add SHALL be digit-serial with decimal carry; if the sum exceeds 9999, bcd <= 9999 (saturate).
REQ-021 Tick with bcd > 0 and no accepted add: bcd <= bcd - 1 in BCD (e.g. 0100 -> 0099, 1000 -> 0999).
REQ-022 Tick in the same cycle as an accepted add: tick SHALL set a pending flag; decrement applied on the next cycle with no add; at most one pending tick.
REQ-023 Tick with bcd == 0000: no change; no underflow; pending flag cleared.
REQ-024 Any digit input value > 9 is never produced; every bcd output digit SHALL be 0..9.
REQ-025 Display FSM states: SOLID, BLINK, FLASH; state chosen each cycle from next bcd value.
REQ-026 SOLID (bcd >= 0200): disp_en = 1 constantly.
REQ-027 BLINK (0001..0199): disp_en toggles on each tick (1 s on, 1 s off); on entry from SOLID, disp_en = 1.
REQ-028 FLASH (0000): disp_en toggles on each half tick (0.5 s on, 0.5 s off); on entry, disp_en = 1.
REQ-029 expired SHALL equal (bcd == 0000) in the same cycle as bcd.
REQ-030 While ld15/ld185 high, disp_en = 1 and the display FSM = BLINK with phase held on.
REQ-031 Release of ld15/ld185: prescaler starts from 0, so the first decrement follows exactly TICK_DIV cycles later.

Reset
REQ-032 On clr_n low (any time, asynchronous): bcd = 0000, expired = 1, disp_en = 1, state FLASH, prescaler = 0, pending flag = 0.
REQ-033 Release of clr_n SHALL be sampled synchronously; the first prescaler increment occurs on the first clk edge with clr_n high.
REQ-034 Reset mid-add or mid-tick SHALL discard that event; no partial digit update visible.

Verification (TICK_DIV = 10)
REQ-035 Reset, hold ld185 for 3 cycles, release -> bcd = 0185, disp_en = 1; after 10 cycles bcd = 0184; after 10 more cycles 0183; disp_en toggles each tick.
REQ-036 bcd = 9990, pulse add550 -> bcd = 9999 next cycle; pulse add10 -> stays 9999; state SOLID, disp_en = 1.
REQ-037 bcd = 0001, let one tick pass -> bcd = 0000, expired = 1; disp_en toggles every 5 cycles; further ticks leave 0000.
REQ-038 add10 and add200 in the same cycle as a tick, bcd = 0195 -> bcd = 0205 then 0204 the following cycle (add200 dropped; pending tick applied); state SOLID.
REQ-039 bcd = 1000, tick -> 0999; bcd = 0200, tick -> 0199 and state BLINK, disp_en = 1 on entry.
REQ-040 ld15 and ld185 both high during add550 pulse -> bcd = 0185; assert clr_n low mid-count -> bcd = 0000 immediately, without waiting for a clk edge.
